// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IM/DM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_owner_e;

  localparam int ADDR_W_DEFAULT = 14;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [DATA_W_DEFAULT-1:0] BWEB_NONE = '1;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while fetch is waiting.
module mem_arb_starve_cnt #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA_STREAK);

  logic [CW-1:0] cnt;

  // Clear wins over increment; increment saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data memory.
// Data has priority; a streak limit forces a fetch grant to avoid starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_bweb,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [DATA_W-1:0] sram_bweb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  resp_owner_e resp_q, resp_d;
  logic        at_max;
  logic        dm_write;

  mem_arb_starve_cnt #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dm_gnt && if_req),
    .clr   (if_gnt || !if_req),
    .at_max(at_max)
  );

  // Same-cycle grant decision: data first unless fetch has waited too long.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if_gnt = if_req && (!dm_req || at_max);
      dm_gnt = dm_req && !if_gnt;
    end
  end

  assign dm_write = dm_gnt && dm_we;

  // Drive the SRAM from whichever requester won; idle values otherwise.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (if_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = if_addr;
    end else if (dm_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = dm_addr;
      if (dm_write) begin
        sram_web  = 1'b0;
        sram_bweb = dm_bweb;
        sram_di   = dm_wdata;
      end
    end
  end

  // Next response owner: only reads produce a response.
  always_comb begin
    resp_d = RESP_NONE;
    if (if_gnt) begin
      resp_d = RESP_IF;
    end else if (dm_gnt && !dm_we) begin
      resp_d = RESP_DM;
    end
  end

  // Response owner register, dropped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Gating with rst also discards a read granted just before reset rose.
  always_comb begin
    if_rvalid = !rst && (resp_q == RESP_IF);
    dm_rvalid = !rst && (resp_q == RESP_DM);
    if_rdata  = if_rvalid ? sram_do : '0;
    dm_rdata  = dm_rvalid ? sram_do : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int VW   = 6 + 3 * DW + AW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, dm_bweb, sram_do;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          sram_ceb, sram_web;
  logic [DW-1:0] sram_bweb, sram_di;
  logic [AW-1:0] sram_a;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_bweb(dm_bweb), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  int vec  = 0;
  int errs = 0;

  // Model: how many data wins fetch has sat through, and who owns next cycle's data.
  int m_streak = 0;
  int m_pend   = 0;  // 0 nobody, 1 fetch, 2 data
  bit g_if, g_dm;
  logic [VW-1:0] exp_vec;

  function automatic logic [VW-1:0] observed();
    return {if_gnt, dm_gnt, if_rvalid, dm_rvalid, sram_ceb, sram_web,
            if_rdata, dm_rdata, sram_bweb, sram_a, sram_di, sram_do};
  endfunction

  task automatic model_eval();
    bit wr;
    logic [DW-1:0] bw, di;
    logic [AW-1:0] a;
    g_if = !rst && if_req && (!dm_req || m_streak == MAXS);
    g_dm = !rst && dm_req && !g_if;
    wr   = g_dm && dm_we;
    bw   = wr ? dm_bweb : BWEB_NONE;
    di   = wr ? dm_wdata : '0;
    a    = g_if ? if_addr : (g_dm ? dm_addr : '0);
    exp_vec = {g_if, g_dm, !rst && m_pend == 1, !rst && m_pend == 2,
               !(g_if || g_dm), !wr,
               (!rst && m_pend == 1) ? sram_do : 32'h0,
               (!rst && m_pend == 2) ? sram_do : 32'h0,
               bw, a, di, sram_do};
  endtask

  task automatic model_clock();
    if (rst) begin
      m_streak = 0;
      m_pend   = 0;
    end else begin
      m_pend = g_if ? 1 : ((g_dm && !dm_we) ? 2 : 0);
      if (g_if || !if_req) m_streak = 0;
      else if (g_dm && m_streak < MAXS) m_streak++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; dm_req = 1; dm_we = 0;
    if_addr = 14'h0111; dm_addr = 14'h0222; dm_wdata = 0; dm_bweb = '1; sram_do = 0;
    g_if = 0; g_dm = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sram_do = $urandom;
      model_eval();
      @(negedge clk);
      vec++;
      if (observed() !== exp_vec) begin
        errs++; $display("FAIL reset cyc%0d got=%h exp=%h", i, observed(), exp_vec);
      end
      vec++;
      if ({if_gnt, dm_gnt, sram_ceb, sram_web, if_rvalid, dm_rvalid} !== 6'b001100) begin
        errs++; $display("FAIL reset_idle got=%b exp=001100",
                         {if_gnt, dm_gnt, sram_ceb, sram_web, if_rvalid, dm_rvalid});
      end
    end
    if_req = 0; dm_req = 0;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_fetch_read();
    if_req = 1; if_addr = 14'h0010; dm_req = 0; sram_do = 0;
    model_eval();
    @(negedge clk);
    vec++;
    if (observed() !== exp_vec) begin
      errs++; $display("FAIL fetch_grant got=%h exp=%h", observed(), exp_vec);
    end
    vec++;
    if ({if_gnt, sram_ceb, sram_a} !== {1'b1, 1'b0, 14'h0010}) begin
      errs++; $display("FAIL fetch_sram got=%b/%b/%h exp=1/0/0010", if_gnt, sram_ceb, sram_a);
    end
    next_cycle();
    if_req = 0; sram_do = 32'hDEADBEEF;
    model_eval();
    @(negedge clk);
    vec++;
    if ({if_rvalid, dm_rvalid, if_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errs++; $display("FAIL fetch_resp got=%b/%b/%h exp=1/0/deadbeef", if_rvalid, dm_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 14'h0100; dm_addr = 14'h0200;
    for (int k = 0; k < 15; k++) begin
      sram_do = $urandom;
      model_eval();
      @(negedge clk);
      vec++;
      if (observed() !== exp_vec) begin
        errs++; $display("FAIL contention cyc%0d got=%h exp=%h", k, observed(), exp_vec);
      end
      vec++;
      if ({if_gnt, dm_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL contention_pattern cyc%0d got=%b exp=%b", k, {if_gnt, dm_gnt},
                         (k % 5 == 4) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    if_req = 0; dm_req = 0;
    model_eval();
    next_cycle();
  endtask

  task automatic test_write();
    dm_req = 1; dm_we = 1; dm_addr = 14'h0020; dm_wdata = 32'h12345678; dm_bweb = 32'hFFFF0000;
    model_eval();
    @(negedge clk);
    vec++;
    if ({sram_web, sram_bweb, sram_di, sram_a} !== {1'b0, 32'hFFFF0000, 32'h12345678, 14'h0020}) begin
      errs++; $display("FAIL write_drive got=%b/%h/%h/%h exp=0/ffff0000/12345678/0020",
                       sram_web, sram_bweb, sram_di, sram_a);
    end
    next_cycle();
    dm_bweb = '1; dm_wdata = 32'hA5A5A5A5;  // all-ones mask: still issued
    model_eval();
    @(negedge clk);
    vec++;
    if (observed() !== exp_vec || {if_rvalid, dm_rvalid} !== 2'b00) begin
      errs++; $display("FAIL write_noresp got=%h exp=%h", observed(), exp_vec);
    end
    next_cycle();
    dm_req = 0; dm_we = 0;
    model_eval();
    @(negedge clk);
    vec++;
    if ({if_rvalid, dm_rvalid} !== 2'b00) begin
      errs++; $display("FAIL write_noresp2 got=%b exp=00", {if_rvalid, dm_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 6; k++) begin
      if_req = (k % 2 == 0); dm_req = (k % 2 == 1); dm_we = 0;
      if_addr = 14'(k); dm_addr = 14'(k + 100); sram_do = 32'(k);
      model_eval();
      @(negedge clk);
      vec++;
      if (observed() !== exp_vec) begin
        errs++; $display("FAIL alternating cyc%0d got=%h exp=%h", k, observed(), exp_vec);
      end
      next_cycle();
    end
    if_req = 0; dm_req = 0;
    model_eval();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    dm_req = 1; dm_we = 0; dm_addr = 14'h0033;
    model_eval();
    @(negedge clk);
    next_cycle();
    rst = 1; dm_req = 0; if_req = 1; sram_do = 32'hCAFE0001;
    model_eval();
    @(negedge clk);
    vec++;
    if ({dm_rvalid, dm_rdata, sram_ceb, if_gnt, dm_gnt} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errs++; $display("FAIL reset_mid got=%b/%h/%b/%b/%b exp=0/0/1/0/0",
                       dm_rvalid, dm_rdata, sram_ceb, if_gnt, dm_gnt);
    end
    next_cycle();
    rst = 0; if_addr = 14'h0044;
    model_eval();
    @(negedge clk);
    vec++;
    if ({if_gnt, dm_rvalid, sram_a} !== {1'b1, 1'b0, 14'h0044}) begin
      errs++; $display("FAIL reset_mid_after got=%b/%b/%h exp=1/0/0044", if_gnt, dm_rvalid, sram_a);
    end
    next_cycle();
    if_req = 0;
    model_eval();
    next_cycle();
  endtask

  task automatic test_dm_only();
    dm_req = 1; dm_we = 0; if_req = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 10) if_req = 1;
      dm_addr = 14'($urandom); sram_do = $urandom;
      model_eval();
      @(negedge clk);
      vec++;
      if (observed() !== exp_vec) begin
        errs++; $display("FAIL dm_only cyc%0d got=%h exp=%h", k, observed(), exp_vec);
      end
      vec++;
      if (if_gnt !== (k == 14)) begin
        errs++; $display("FAIL dm_only_wait cyc%0d if_gnt got=%b exp=%b", k, if_gnt, (k == 14));
      end
      next_cycle();
    end
    if_req = 0; dm_req = 0;
    model_eval();
    next_cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (!(if_req && !g_if)) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = 14'($urandom);
      end
      if (!(dm_req && !g_dm)) begin
        dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
        dm_addr = 14'($urandom); dm_wdata = $urandom; dm_bweb = $urandom;
      end
      sram_do = $urandom;
      model_eval();
      @(negedge clk);
      vec++;
      if (observed() !== exp_vec) begin
        errs++; $display("FAIL random cyc%0d got=%h exp=%h", k, observed(), exp_vec);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_contention();
    test_write();
    test_alternating();
    test_reset_mid();
    test_dm_only();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
